// File: rtl/debug_pkg.sv
// Shared definitions for the debug button front end: button indices,
// cursor reset pattern and the cursor-to-digit-select decode.
package debug_pkg;

  typedef enum logic [2:0] {
    BTN_UP     = 3'd0,
    BTN_DOWN   = 3'd1,
    BTN_LEFT   = 3'd2,
    BTN_RIGHT  = 3'd3,
    BTN_CENTER = 3'd4
  } btn_e;

  localparam int NUM_BTNS = 5;

  localparam logic [3:0] DIGIT_SEL_RESET = 4'b1110;

  // Active-low one-hot digit select for a cursor index (0 = least significant digit)
  function automatic logic [3:0] digit_sel_from_index(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button channel: 2-flop synchronizer, stability-counting debouncer
// and a rising-edge press detector on the debounced level.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_0;
  logic             sync_1;
  logic [CNT_W-1:0] count;
  logic             level_prev;

  // Two-stage synchronizer to bring the asynchronous button into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_0 <= 1'b0;
      sync_1 <= 1'b0;
    end else begin
      sync_0 <= btn_raw;
      sync_1 <= sync_0;
    end
  end

  // Count consecutive cycles the synchronized input disagrees with the level; flip once it has held long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      level <= 1'b0;
    end else if (sync_1 == level) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      count <= '0;
      level <= ~level;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Remember the previous debounced level so only a 0->1 transition counts as a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev <= 1'b0;
    end else begin
      level_prev <= level;
    end
  end

  assign press = level & ~level_prev;

endmodule

// File: rtl/debug_input.sv
// Debug-path button front end: debounces five buttons and edits a 16-bit
// hex value one nybble at a time, with a cursor and a commit strobe.
module debug_input
  import debug_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 200000,
  parameter logic [15:0] INIT_VALUE      = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  output logic [15:0] number_out,
  output logic [3:0]  digit_sel,
  output logic        commit,
  output logic [4:0]  btn_level
);

  logic [NUM_BTNS-1:0] raw_btns;
  logic [NUM_BTNS-1:0] levels;
  logic [NUM_BTNS-1:0] press;

  logic [15:0] number_q;
  logic [15:0] number_next;
  logic [1:0]  cursor_idx;
  logic [1:0]  idx_next;
  logic [3:0]  digit_sel_q;
  logic        commit_q;
  logic [3:0]  nybble;

  assign raw_btns = {btn_center, btn_right, btn_left, btn_down, btn_up};

  genvar g;
  generate
    for (g = 0; g < NUM_BTNS; g++) begin : g_btn
      button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(raw_btns[g]),
        .level  (levels[g]),
        .press  (press[g])
      );
    end
  endgenerate

  // Edit the nybble under the current cursor and then move the cursor; opposing presses cancel out
  always_comb begin
    number_next = number_q;
    idx_next    = cursor_idx;
    nybble      = number_q[{cursor_idx, 2'b00} +: 4];
    if (press[BTN_UP] && !press[BTN_DOWN]) begin
      number_next[{cursor_idx, 2'b00} +: 4] = nybble + 4'd1;
    end else if (press[BTN_DOWN] && !press[BTN_UP]) begin
      number_next[{cursor_idx, 2'b00} +: 4] = nybble - 4'd1;
    end
    if (press[BTN_LEFT] && !press[BTN_RIGHT]) begin
      idx_next = cursor_idx + 2'd1;
    end else if (press[BTN_RIGHT] && !press[BTN_LEFT]) begin
      idx_next = cursor_idx - 2'd1;
    end
  end

  // Register the edited value, cursor, its display decode and the commit strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      number_q    <= INIT_VALUE;
      cursor_idx  <= 2'd0;
      digit_sel_q <= DIGIT_SEL_RESET;
      commit_q    <= 1'b0;
    end else begin
      number_q    <= number_next;
      cursor_idx  <= idx_next;
      digit_sel_q <= digit_sel_from_index(idx_next);
      commit_q    <= press[BTN_CENTER];
    end
  end

  assign number_out = number_q;
  assign digit_sel  = digit_sel_q;
  assign commit     = commit_q;
  assign btn_level  = levels;

endmodule

// File: doc/debug_input.md
# debug_input

Board-button front end for the debug path. It synchronizes and debounces five push buttons and lets an operator edit a 16-bit hex value one nybble at a time. That value, plus the active-digit cursor, feeds the seven-segment debug display and any debug consumer, such as breakpoint address or register poke. A center-button press emits a one-cycle commit strobe.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 200000: consecutive stable synchronized cycles required before a debounced level changes; legal range ≥ 1.
- INIT_VALUE, 16'h0000: number_out value after reset.

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst_n  input  1  reset, asynchronous and active-low.
- btn_up  input  1  raw, asynchronous button; increments the selected nybble.
- btn_down  input  1  raw, asynchronous button; decrements the selected nybble.
- btn_left  input  1  raw, asynchronous button; moves the cursor one digit more significant.
- btn_right  input  1  raw, asynchronous button; moves the cursor one digit less significant.
- btn_center  input  1  raw, asynchronous button; commit.
- number_out  output  16  edited value, registered.
- digit_sel  output  4  cursor position, active-low one-hot: 4'b1110 selects digit 0 (bits 3:0) and 4'b0111 selects digit 3 (bits 15:12). Drives the display's digit-active convention directly.
- commit  output  1  one-cycle pulse per center press.
- btn_level  output  5  debounced levels, indexed {center, right, left, down, up}.

## Operation
- Per button: a 2-flop synchronizer, then a debouncer, then a rising-edge detector.
  - The debouncer counter resets to 0 whenever the synchronized input equals the debounced level.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES−1, the debounced level toggles and the counter clears.
  - A press event is a 0→1 transition of the debounced level. Releases produce no event.
- up event: selected nybble +1 modulo 16. F→0 wraps with no carry into the neighbouring nybble.
- down event: selected nybble −1 modulo 16. 0→F wraps with no borrow.
- left event: cursor index +1; index 3 wraps to 0.
- right event: cursor index −1; index 0 wraps to 3.
- center event: commit high for exactly one cycle.
- Simultaneous events in one cycle:
  - up and down together: the value is unchanged.
  - left and right together: the cursor is unchanged.
  - A value edit together with a cursor move: the edit applies to the cursor position before the move.
  - Commit is independent of the other events. The number_out in the commit cycle already includes any same-cycle edit.
- Held buttons do not auto-repeat. Each press requires a release, debounced, before the next press.
- Reset values:
  - number_out = INIT_VALUE, digit_sel = 4'b1110, commit = 0, btn_level = 5'b0.
  - Synchronizers, counters and debounced levels all clear to 0.
- Reset asserted mid-operation clears all state immediately, with an asynchronous assert. If a button is held through reset release, it must debounce again from zero and then produces one press event.

## Timing
- A raw input edge is visible at the synchronizer output after 2 clk edges.
- The debounced level changes DEBOUNCE_CYCLES cycles after the synchronized value first differs, provided it stays stable for that whole window.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- number_out, digit_sel and commit update on the clk edge after the cycle in which the debounced level rises (1-cycle registered latency).
- Total press latency from a clean raw edge is DEBOUNCE_CYCLES + 3 cycles, with a jitter of 0 to 1 cycle from synchronizer sampling.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package debug_pkg holds:
  - the btn_e enum (BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_CENTER=4) and NUM_BTNS=5;
  - DIGIT_SEL_RESET = 4'b1110.
- One sub-module, button_debouncer, parameterized by DEBOUNCE_CYCLES. It contains the synchronizer, the counter of width $clog2(DEBOUNCE_CYCLES+1), and the level and press-pulse outputs. It is instantiated NUM_BTNS times via a generate loop.
- The top level holds the edit/cursor datapath and the output registers.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4 and INIT_VALUE=16'h0000.
- Reset: assert rst_n=0 mid-cycle -> all outputs immediately 0, digit_sel=4'b1110; hold 10 cycles -> no change.
- Clean up press held 20 cycles -> number_out=16'h0001 exactly once, about 7 cycles after the edge; releasing gives no further change.
- Sixteen up presses on digit 0, then one left press and one down press -> number_out=16'h00F0 (digit 0 wrapped to 0, digit 1 0→F), digit_sel=4'b1101.
- Bounce: a 3-cycle pulse on btn_up, then random 1–3-cycle toggles for 30 cycles -> number_out unchanged, btn_level[0]=0.
- Simultaneous events:
  - up+down in the same debounce cycle -> number_out unchanged.
  - up+left together starting at digit 0 -> number_out=16'h0001 and digit_sel=4'b1101.
  - center pressed alongside -> commit high for exactly 1 cycle, with number_out already updated.
- Button held across reset release -> exactly one press event, after DEBOUNCE_CYCLES+3 cycles; right pressed from digit 0 -> digit_sel=4'b0111.
